// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the voice waveshaper
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_OFF    = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_SHAPE  = 2'd2
  } state_t;

  localparam logic [7:0] SAMPLE_MID = 8'h80;

endpackage

// File: rtl/phase_divider.sv
// rtl/phase_divider.sv - restoring fractional divider, one quotient bit per clock, MSB first
module phase_divider #(
  parameter int CNT_W    = 18,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    dividend,
  input  logic [CNT_W-1:0]    divisor,
  output logic                last,
  output logic [SAMPLE_W-1:0] quotient
);

  localparam int IW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

  logic             running;
  logic [IW-1:0]    iter;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W:0]   rem2;
  logic             take;

  // rem stays below the divisor, so only the doubled value needs the extra bit
  always_comb begin
    rem2 = {rem, 1'b0};
    take = (rem2 >= {1'b0, div_r});
  end

  // last is high during the cycle whose edge produces the final quotient bit
  assign last = running && (iter == IW'(SAMPLE_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      iter     <= '0;
      rem      <= '0;
      div_r    <= '0;
      quotient <= '0;
    end else if (start) begin
      running  <= 1'b1;
      iter     <= '0;
      rem      <= dividend;
      div_r    <= divisor;
      quotient <= '0;
    end else if (running) begin
      rem      <= take ? CNT_W'(rem2 - {1'b0, div_r}) : rem2[CNT_W-1:0];
      quotient <= {quotient[SAMPLE_W-2:0], take};
      iter     <= iter + 1'b1;
      if (last) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/osc_waveshaper.sv
// rtl/osc_waveshaper.sv - snapshots oscillator phase, divides to a fraction, shapes a voice sample
module osc_waveshaper
  import synth_pkg::*;
#(
  parameter int CNT_W    = 18,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CNT_W-1:0]    count,
  input  logic [CNT_W-1:0]    divisor,
  input  logic [1:0]          wave_sel,
  input  logic                sample_req,
  output logic                busy,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                overrun
);

  state_t                state;
  wave_t                 wave_lat;
  logic                  skip_div;
  logic [CNT_W-1:0]      c_clamp;
  logic                  div_start;
  logic                  div_last;
  logic [SAMPLE_W-1:0]   quotient;
  logic [SAMPLE_W-1:0]   phase;
  logic [SAMPLE_W-1:0]   shaped;

  always_comb begin
    if (count == '0)
      c_clamp = CNT_W'(1);
    else if (count > divisor)
      c_clamp = divisor;
    else
      c_clamp = count;
  end

  assign div_start = (state == ST_IDLE) && sample_req && (divisor != '0);

  phase_divider #(
    .CNT_W    (CNT_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (c_clamp - CNT_W'(1)),
    .divisor  (divisor),
    .last     (div_last),
    .quotient (quotient)
  );

  // a zero-period oscillator has no meaningful phase; treat it as phase 0
  assign phase = skip_div ? '0 : quotient;

  always_comb begin
    shaped = SAMPLE_W'(SAMPLE_MID);
    case (wave_lat)
      WAVE_SAW:    shaped = phase;
      WAVE_SQUARE: shaped = phase[SAMPLE_W-1] ? '0 : '1;
      WAVE_TRI:    shaped = phase[SAMPLE_W-1] ? ~{phase[SAMPLE_W-2:0], 1'b0}
                                              :  {phase[SAMPLE_W-2:0], 1'b0};
      default:     shaped = SAMPLE_W'(SAMPLE_MID);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wave_lat     <= WAVE_OFF;
      skip_div     <= 1'b0;
      busy         <= 1'b0;
      sample       <= SAMPLE_W'(SAMPLE_MID);
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= sample_req && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (sample_req) begin
            wave_lat <= wave_t'(wave_sel);
            skip_div <= (divisor == '0);
            busy     <= 1'b1;
            state    <= (divisor == '0) ? ST_SHAPE : ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (div_last) begin
            state <= ST_SHAPE;
          end
        end
        ST_SHAPE: begin
          sample       <= shaped;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_waveshaper.sv
// tb/tb_osc_waveshaper.sv - scoreboard bench for osc_waveshaper
module tb_osc_waveshaper;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] count;
  logic [17:0] divisor;
  logic [1:0]  wave_sel;
  logic        sample_req;
  logic        busy;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        overrun;

  typedef struct {
    logic [7:0] s;
    int         due;
  } exp_t;

  typedef struct {
    logic [17:0] c;
    logic [17:0] d;
    logic [1:0]  w;
    logic [7:0]  s;
  } vec_t;

  exp_t exp_q[$];
  int   ovr_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  bit   prev_valid = 1'b0;

  osc_waveshaper dut (
    .clk          (clk),
    .rst          (rst),
    .count        (count),
    .divisor      (divisor),
    .wave_sel     (wave_sel),
    .sample_req   (sample_req),
    .busy         (busy),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // monitor: every output event is matched against the scoreboard queues
  always @(negedge clk) begin
    exp_t e;
    int   o;
    if (sample_valid) begin
      check(!prev_valid, "valid_back_to_back", 1, 0);
      check(exp_q.size() != 0, "unexpected_valid", sample, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(sample == e.s, "sample_value", sample, e.s);
        check(cyc == e.due, "valid_latency_cycle", cyc, e.due);
      end
    end
    if (overrun) begin
      check(ovr_q.size() != 0, "unexpected_overrun", cyc, 0);
      if (ovr_q.size() != 0) begin
        o = ovr_q.pop_front();
        check(cyc == o, "overrun_cycle", cyc, o);
      end
    end
    prev_valid = sample_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: accepted with result, 1: dropped with overrun, 2: accepted but result aborted
  task automatic drive_req(input logic [17:0] c, input logic [17:0] d, input logic [1:0] w,
                           input logic [7:0] s, input int mode);
    exp_t e;
    count      = c;
    divisor    = d;
    wave_sel   = w;
    sample_req = 1'b1;
    if (mode == 0) begin
      e.s   = s;
      e.due = cyc + 1 + ((d == 18'd0) ? 1 : 9);
      exp_q.push_back(e);
    end else if (mode == 1) begin
      ovr_q.push_back(cyc + 1);
    end
    step(1);
    sample_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(n < 40, "busy_timeout", n, 40);
  endtask

  vec_t vecs[] = '{
    '{18'd26,     18'd100,    2'd1, 8'h40},
    '{18'd26,     18'd100,    2'd2, 8'hFF},
    '{18'd26,     18'd100,    2'd3, 8'h80},
    '{18'd51,     18'd100,    2'd1, 8'h80},
    '{18'd51,     18'd100,    2'd2, 8'h00},
    '{18'd51,     18'd100,    2'd3, 8'hFF},
    '{18'd100,    18'd100,    2'd1, 8'hFD},
    '{18'd0,      18'd100,    2'd1, 8'h00},
    '{18'd150,    18'd100,    2'd1, 8'hFD},
    '{18'd5,      18'd0,      2'd1, 8'h00},
    '{18'd51,     18'd100,    2'd0, 8'h80},
    '{18'd3,      18'd3,      2'd1, 8'hAA},
    '{18'd3,      18'd3,      2'd3, 8'hAB},
    '{18'd3,      18'd3,      2'd2, 8'h00},
    '{18'd131072, 18'd262143, 2'd1, 8'h7F},
    '{18'd7,      18'd0,      2'd0, 8'h80}
  };

  initial begin
    rst        = 1'b1;
    count      = '0;
    divisor    = '0;
    wave_sel   = '0;
    sample_req = 1'b0;
    step(3);
    check(sample == 8'h80, "reset_sample", sample, 8'h80);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(sample_valid == 1'b0, "reset_valid", sample_valid, 0);
    check(overrun == 1'b0, "reset_overrun", overrun, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(1);
      drive_req(vecs[i].c, vecs[i].d, vecs[i].w, vecs[i].s, 0);
      wait_idle();
    end

    // inputs scrambled during the conversion must not leak into the result
    step(1);
    drive_req(18'd76, 18'd200, 2'd3, 8'hC0, 0);
    for (int k = 0; k < 9; k++) begin
      count    = 18'($urandom);
      divisor  = 18'($urandom);
      wave_sel = 2'($urandom);
      step(1);
    end
    wait_idle();

    // second request while busy is dropped; request in the valid cycle is taken
    step(1);
    drive_req(18'd26, 18'd100, 2'd1, 8'h40, 0);
    step(2);
    drive_req(18'd0, 18'd0, 2'd0, 8'h00, 1);
    step(6);
    drive_req(18'd100, 18'd100, 2'd1, 8'hFD, 0);
    wait_idle();

    // reset in the middle of a conversion aborts it
    step(1);
    drive_req(18'd51, 18'd100, 2'd2, 8'h00, 2);
    step(3);
    rst = 1'b1;
    step(1);
    check(sample == 8'h80, "midreset_sample", sample, 8'h80);
    check(busy == 1'b0, "midreset_busy", busy, 0);
    check(sample_valid == 1'b0, "midreset_valid", sample_valid, 0);
    rst = 1'b0;
    step(12);
    drive_req(18'd51, 18'd100, 2'd2, 8'h00, 0);
    wait_idle();

    step(5);
    check(exp_q.size() == 0, "pending_results", exp_q.size(), 0);
    check(ovr_q.size() == 0, "pending_overruns", ovr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
